// File: rtl/control_unit_pkg.sv
// Shared types and constants for the control unit and its opcode decoder.
package control_unit_pkg;

  localparam int unsigned CU_OPCODE_WIDTH  = 4;
  localparam int unsigned CU_OPERAND_WIDTH = 12;

  typedef enum logic [CU_OPCODE_WIDTH-1:0] {
    OP_NOP   = 4'h0,
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_AND   = 4'h5,
    OP_OR    = 4'h6,
    OP_XOR   = 4'h7,
    OP_NOT   = 4'h8,
    OP_JMP   = 4'h9,
    OP_JZ    = 4'hA,
    OP_JN    = 4'hB,
    OP_LDI   = 4'hC,
    OP_ILL_D = 4'hD,
    OP_ILL_E = 4'hE,
    OP_HLT   = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_FETCH,
    ST_DECODE,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_WRITEBACK,
    ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_PASS_MEM = 3'd0,
    ALU_ADD      = 3'd1,
    ALU_SUB      = 3'd2,
    ALU_AND      = 3'd3,
    ALU_OR       = 3'd4,
    ALU_XOR      = 3'd5,
    ALU_NOT      = 3'd6,
    ALU_PASS_OPD = 3'd7
  } alu_op_e;

  // What DECODE should do next for the current opcode and flags.
  typedef enum logic [2:0] {
    DEC_NEXT,
    DEC_BRANCH,
    DEC_MEM_RD,
    DEC_MEM_WR,
    DEC_WRITEBACK,
    DEC_HALT,
    DEC_ILLEGAL
  } dec_action_e;

  typedef struct packed {
    dec_action_e action;
    alu_op_e     alu_op;
  } dec_t;

endpackage

// File: rtl/control_decoder.sv
// Combinational opcode-to-control decode; branch conditions resolved here.
module control_decoder
  import control_unit_pkg::*;
(
  input  logic [CU_OPCODE_WIDTH-1:0] opcode,
  input  logic                       acc_zero,
  input  logic                       acc_neg,
  output dec_t                       dec
);

  // Map each opcode to a DECODE action and the ALU operation it uses.
  always_comb begin
    dec.action = DEC_NEXT;
    dec.alu_op = ALU_PASS_MEM;
    case (opcode_e'(opcode))
      OP_NOP:   dec.action = DEC_NEXT;
      OP_LOAD:  begin dec.action = DEC_MEM_RD;    dec.alu_op = ALU_PASS_MEM; end
      OP_STORE: dec.action = DEC_MEM_WR;
      OP_ADD:   begin dec.action = DEC_MEM_RD;    dec.alu_op = ALU_ADD;      end
      OP_SUB:   begin dec.action = DEC_MEM_RD;    dec.alu_op = ALU_SUB;      end
      OP_AND:   begin dec.action = DEC_MEM_RD;    dec.alu_op = ALU_AND;      end
      OP_OR:    begin dec.action = DEC_MEM_RD;    dec.alu_op = ALU_OR;       end
      OP_XOR:   begin dec.action = DEC_MEM_RD;    dec.alu_op = ALU_XOR;      end
      OP_NOT:   begin dec.action = DEC_WRITEBACK; dec.alu_op = ALU_NOT;      end
      OP_JMP:   dec.action = DEC_BRANCH;
      OP_JZ:    dec.action = acc_zero ? DEC_BRANCH : DEC_NEXT;
      OP_JN:    dec.action = acc_neg  ? DEC_BRANCH : DEC_NEXT;
      OP_LDI:   begin dec.action = DEC_WRITEBACK; dec.alu_op = ALU_PASS_OPD; end
      OP_HLT:   dec.action = DEC_HALT;
      default:  dec.action = DEC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM: fetch, decode, memory access, writeback, halt.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int unsigned INSTRUCTION_REGISTER = 16,
  parameter int unsigned OPCODE_WIDTH         = 4,
  parameter int unsigned WAIT_LIMIT           = 15
) (
  input  logic                                     clock,
  input  logic                                     cu_reset,
  input  logic [INSTRUCTION_REGISTER-1:0]          cu_ir_in,
  input  logic                                     cu_mem_ready,
  input  logic                                     cu_acc_zero,
  input  logic                                     cu_acc_neg,
  output logic                                     cu_ir_wr,
  output logic                                     cu_ir_reset,
  output logic                                     cu_pc_inc,
  output logic                                     cu_pc_wr,
  output logic                                     cu_mem_rd,
  output logic                                     cu_mem_wr,
  output logic                                     cu_addr_sel,
  output logic                                     cu_acc_wr,
  output logic [2:0]                               cu_alu_op,
  output logic [INSTRUCTION_REGISTER-OPCODE_WIDTH-1:0] cu_operand,
  output logic                                     cu_halted,
  output logic                                     cu_fault,
  output logic [15:0]                              cu_instr_count
);

  localparam int unsigned WAIT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

  state_e                state, state_nxt;
  logic [WAIT_W-1:0]     wait_cnt, wait_nxt;
  logic                  fault, set_fault, retire, wait_done;
  logic [15:0]           instr_count;
  logic [CU_OPCODE_WIDTH-1:0] opcode;
  dec_t                  dec;

  logic    ir_wr, pc_inc, pc_wr, mem_rd, mem_wr, addr_sel, acc_wr, halted;
  alu_op_e alu_op;

  assign opcode     = cu_ir_in[INSTRUCTION_REGISTER-1 -: CU_OPCODE_WIDTH];
  assign cu_operand = cu_ir_in[INSTRUCTION_REGISTER-OPCODE_WIDTH-1:0];
  assign wait_done  = (wait_cnt == WAIT_W'(WAIT_LIMIT - 1));

  control_decoder u_decoder (
    .opcode   (opcode),
    .acc_zero (cu_acc_zero),
    .acc_neg  (cu_acc_neg),
    .dec      (dec)
  );

  // State, wait counter, sticky fault and retired-instruction counter.
  always_ff @(posedge clock) begin
    if (cu_reset) begin
      state       <= ST_INIT;
      wait_cnt    <= '0;
      fault       <= 1'b0;
      instr_count <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (set_fault) fault <= 1'b1;
      if (retire) instr_count <= instr_count + 16'd1;
    end
  end

  // Next-state and per-state outputs; wait_nxt defaults to 0 so any state change clears it.
  always_comb begin
    state_nxt   = state;
    wait_nxt    = '0;
    set_fault   = 1'b0;
    retire      = 1'b0;
    ir_wr       = 1'b0;
    cu_ir_reset = 1'b0;
    pc_inc      = 1'b0;
    pc_wr       = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    addr_sel    = 1'b0;
    acc_wr      = 1'b0;
    alu_op      = ALU_PASS_MEM;
    halted      = 1'b0;
    case (state)
      ST_INIT: begin
        cu_ir_reset = 1'b1;
        state_nxt   = ST_FETCH;
      end
      ST_FETCH: begin
        mem_rd = 1'b1;
        if (cu_mem_ready) begin
          ir_wr     = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = ST_DECODE;
        end else if (wait_done) begin
          state_nxt = ST_HALT;
          set_fault = 1'b1;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      ST_DECODE: begin
        case (dec.action)
          DEC_NEXT:      begin state_nxt = ST_FETCH; retire = 1'b1; end
          DEC_BRANCH:    begin pc_wr = 1'b1; state_nxt = ST_FETCH; retire = 1'b1; end
          DEC_MEM_RD:    state_nxt = ST_MEM_RD;
          DEC_MEM_WR:    state_nxt = ST_MEM_WR;
          DEC_WRITEBACK: state_nxt = ST_WRITEBACK;
          DEC_HALT:      state_nxt = ST_HALT;
          default:       begin state_nxt = ST_HALT; set_fault = 1'b1; end
        endcase
      end
      ST_MEM_RD: begin
        mem_rd   = 1'b1;
        addr_sel = 1'b1;
        alu_op   = dec.alu_op;
        if (cu_mem_ready) begin
          state_nxt = ST_WRITEBACK;
        end else if (wait_done) begin
          state_nxt = ST_HALT;
          set_fault = 1'b1;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      ST_MEM_WR: begin
        mem_wr   = 1'b1;
        addr_sel = 1'b1;
        if (cu_mem_ready) begin
          state_nxt = ST_FETCH;
          retire    = 1'b1;
        end else if (wait_done) begin
          state_nxt = ST_HALT;
          set_fault = 1'b1;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      ST_WRITEBACK: begin
        acc_wr    = 1'b1;
        alu_op    = dec.alu_op;
        state_nxt = ST_FETCH;
        retire    = 1'b1;
      end
      ST_HALT: halted = 1'b1;
      default: state_nxt = ST_INIT;
    endcase
  end

  // Reset masks every status/request output; cu_ir_reset and cu_operand pass through.
  assign cu_ir_wr       = ir_wr    & ~cu_reset;
  assign cu_pc_inc      = pc_inc   & ~cu_reset;
  assign cu_pc_wr       = pc_wr    & ~cu_reset;
  assign cu_mem_rd      = mem_rd   & ~cu_reset;
  assign cu_mem_wr      = mem_wr   & ~cu_reset;
  assign cu_addr_sel    = addr_sel & ~cu_reset;
  assign cu_acc_wr      = acc_wr   & ~cu_reset;
  assign cu_alu_op      = cu_reset ? '0 : alu_op;
  assign cu_halted      = halted   & ~cu_reset;
  assign cu_fault       = fault    & ~cu_reset;
  assign cu_instr_count = cu_reset ? '0 : instr_count;

endmodule
